// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with single-cycle logic/arithmetic ops,
// an iterative shift-add multiplier and a persistent multiply-accumulate.
module alu_seq #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  state_t          state_nxt;

  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]    prod;
  logic [CW-1:0]    count;
  logic             is_mac;
  logic [RW-1:0]    acc;

  logic [RW-1:0]    ax;
  logic [RW-1:0]    bx;
  logic [WIDTH:0]   sum_w;
  logic [RW-1:0]    sc_res;
  logic             sc_carry;
  logic             is_iter;
  logic [RW-1:0]    prod_step;
  logic [RW:0]      mac_sum;
  logic             last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign ax        = {{WIDTH{1'b0}}, a};
  assign bx        = {{WIDTH{1'b0}}, b};
  assign is_iter   = (op[2:1] == 2'b11);
  assign last_step = (count == CW'(1));

  // Single-cycle result and flag for the op currently on the input channel.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sum_w    = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin
        sc_res   = {{(WIDTH-1){1'b0}}, sum_w};
        sc_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        sc_res   = ax - bx;
        sc_carry = (a < b);
      end
      OP_AND:  sc_res = ax & bx;
      OP_OR:   sc_res = ax | bx;
      OP_XOR:  sc_res = ax ^ bx;
      OP_SHL:  sc_res = ax << b;
      default: sc_res = '0;
    endcase
  end

  // One shift-add step, plus the accumulator sum used on the final MAC step.
  always_comb begin
    prod_step = prod + (mplier[0] ? mcand : '0);
    mac_sum   = {1'b0, acc} + {1'b0, prod_step};
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = is_iter ? BUSY : DONE;
      BUSY: if (last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, multiplier iteration, result and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      count  <= '0;
      is_mac <= 1'b0;
      acc    <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Clearing here lands before any MAC accumulation of this command.
          if (acc_clr) acc <= '0;
          if (in_valid) begin
            if (is_iter) begin
              mcand  <= ax;
              mplier <= b;
              prod   <= '0;
              count  <= CW'(WIDTH);
              is_mac <= op[0];
            end else begin
              result <= sc_res;
              carry  <= sc_carry;
              zero   <= (sc_res == '0);
            end
          end
        end
        BUSY: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          prod   <= prod_step;
          count  <= count - CW'(1);
          if (last_step) begin
            if (is_mac) begin
              acc    <= mac_sum[RW-1:0];
              result <= mac_sum[RW-1:0];
              carry  <= mac_sum[RW];
              zero   <= (mac_sum[RW-1:0] == '0);
            end else begin
              result <= prod_step;
              carry  <= 1'b0;
              zero   <= (prod_step == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with WIDTH=3.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [2:0] a;
  logic [2:0] b;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] result;
  logic       carry;
  logic       zero;

  int checks;
  int failures;

  alu_seq #(.WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge, then wait (bounded) for out_valid.
  // lat counts edges from the acceptance edge to the one raising out_valid.
  task automatic do_op(input logic [2:0] o, input logic [2:0] x, input logic [2:0] y,
                       input logic clr, output int lat);
    in_valid = 1'b1; op = o; a = x; b = y; acc_clr = clr;
    tick();
    in_valid = 1'b0; acc_clr = 1'b0; op = 3'b000; a = 3'd0; b = 3'd0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 3'd0; b = 3'd0;
    acc_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (result !== 6'd0) begin failures++; $display("FAIL rst_result got=%0d exp=0", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL rst_carry got=%0b exp=0", carry); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL rst_zero got=%0b exp=0", zero); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_add();
    int lat;
    do_op(3'b000, 3'd7, 3'd7, 1'b0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (result !== 6'd14) begin failures++; $display("FAIL add_result got=%0d exp=14", result); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL add_carry got=%0b exp=1", carry); end
    checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%0b exp=0", zero); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_hold_valid got=%0b exp=1", out_valid); end
    pop();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_release_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_sub();
    int lat;
    do_op(3'b001, 3'd2, 3'd5, 1'b0, lat);
    checks++; if (result !== 6'd61) begin failures++; $display("FAIL sub_neg_result got=%0d exp=61", result); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL sub_neg_borrow got=%0b exp=1", carry); end
    pop();
    do_op(3'b001, 3'd4, 3'd4, 1'b0, lat);
    checks++; if (result !== 6'd0) begin failures++; $display("FAIL sub_eq_result got=%0d exp=0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL sub_eq_zero got=%0b exp=1", zero); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL sub_eq_borrow got=%0b exp=0", carry); end
    pop();
  endtask

  task automatic test_logic();
    int lat;
    do_op(3'b010, 3'd6, 3'd3, 1'b0, lat);
    checks++; if (result !== 6'd2) begin failures++; $display("FAIL and_result got=%0d exp=2", result); end
    pop();
    do_op(3'b011, 3'd6, 3'd3, 1'b0, lat);
    checks++; if (result !== 6'd7) begin failures++; $display("FAIL or_result got=%0d exp=7", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL or_carry got=%0b exp=0", carry); end
    pop();
  endtask

  task automatic test_mul_shl();
    int lat;
    do_op(3'b110, 3'd7, 3'd7, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL mul_latency got=%0d exp=4", lat); end
    checks++; if (result !== 6'd49) begin failures++; $display("FAIL mul_result got=%0d exp=49", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL mul_carry got=%0b exp=0", carry); end
    pop();
    do_op(3'b110, 3'd5, 3'd6, 1'b0, lat);
    checks++; if (result !== 6'd30) begin failures++; $display("FAIL mul2_result got=%0d exp=30", result); end
    pop();
    do_op(3'b101, 3'd5, 3'd3, 1'b0, lat);
    checks++; if (result !== 6'd40) begin failures++; $display("FAIL shl_result got=%0d exp=40", result); end
    pop();
    do_op(3'b101, 3'd7, 3'd7, 1'b0, lat);
    checks++; if (result !== 6'd0) begin failures++; $display("FAIL shl_out_result got=%0d exp=0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL shl_out_zero got=%0b exp=1", zero); end
    pop();
  endtask

  task automatic test_mac();
    int lat;
    do_op(3'b111, 3'd3, 3'd5, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL mac_latency got=%0d exp=4", lat); end
    checks++; if (result !== 6'd15) begin failures++; $display("FAIL mac1_result got=%0d exp=15", result); end
    pop();
    do_op(3'b111, 3'd2, 3'd2, 1'b0, lat);
    checks++; if (result !== 6'd19) begin failures++; $display("FAIL mac2_result got=%0d exp=19", result); end
    pop();
    do_op(3'b111, 3'd1, 3'd1, 1'b1, lat);
    checks++; if (result !== 6'd1) begin failures++; $display("FAIL mac_clr_result got=%0d exp=1", result); end
    pop();
    do_op(3'b111, 3'd7, 3'd7, 1'b0, lat);
    checks++; if (result !== 6'd50) begin failures++; $display("FAIL mac3_result got=%0d exp=50", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL mac3_carry got=%0b exp=0", carry); end
    pop();
    do_op(3'b111, 3'd7, 3'd7, 1'b0, lat);
    checks++; if (result !== 6'd35) begin failures++; $display("FAIL mac_ovf_result got=%0d exp=35", result); end
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL mac_ovf_carry got=%0b exp=1", carry); end
    pop();
    do_op(3'b000, 3'd1, 3'd1, 1'b1, lat);
    checks++; if (result !== 6'd2) begin failures++; $display("FAIL add_clr_result got=%0d exp=2", result); end
    pop();
    do_op(3'b111, 3'd1, 3'd1, 1'b0, lat);
    checks++; if (result !== 6'd1) begin failures++; $display("FAIL mac_after_clr got=%0d exp=1", result); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(3'b100, 3'd6, 3'd3, 1'b0, lat);
    checks++; if (result !== 6'd5) begin failures++; $display("FAIL xor_result got=%0d exp=5", result); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'b000; a = 3'd1; b = 3'd1;
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, out_valid); end
      checks++; if (result !== 6'd5) begin failures++; $display("FAIL bp_result[%0d] got=%0d exp=5", i, result); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    pop();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_op(3'b111, 3'd3, 3'd5, 1'b1, lat);
    checks++; if (result !== 6'd15) begin failures++; $display("FAIL rm_setup_result got=%0d exp=15", result); end
    pop();
    in_valid = 1'b1; op = 3'b111; a = 3'd7; b = 3'd7;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", out_valid); end
    checks++; if (result !== 6'd0) begin failures++; $display("FAIL rm_result got=%0d exp=0", result); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL rm_carry got=%0b exp=0", carry); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_no_valid[%0d] got=%0b exp=0", i, out_valid); end
    end
    do_op(3'b111, 3'd1, 3'd1, 1'b0, lat);
    checks++; if (result !== 6'd1) begin failures++; $display("FAIL rm_acc_cleared got=%0d exp=1", result); end
    pop();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul_shl();
    test_mac();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked, sequential ALU: next generation of the team's combinational 3-bit ALU. It keeps ADD/SUB/AND/OR and adds XOR, SHL, an iterative MUL and an accumulating MAC. Operands arrive on a valid/ready input channel and results leave on a valid/ready output channel. It sits between the pin-level input wrapper and the output register file, and tolerates backpressure.

## Interface
- WIDTH, 3, operand width in bits (≥2).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op valid.
- in_ready  out  1  block can accept a command.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 MAC.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- acc_clr  in  1  synchronous accumulator clear request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  result.
- carry  out  1  carry/borrow flag.
- zero  out  1  result == 0.

## Operation
- FSM states are IDLE, BUSY and DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE with in_valid: capture op, a and b.
  - Single-cycle ops (000–101) go to DONE.
  - MUL and MAC load the multiplicand (a zero-extended to 2W), the multiplier (b), a product of 0 and count = WIDTH, then go to BUSY.
- BUSY: one shift-add step per cycle, LSB of the multiplier first. If the multiplier LSB is 1, add the multiplicand to the product. Then shift the multiplicand left by 1, shift the multiplier right by 1 and decrement count. When count reaches 1, the final step runs, the result is written and the state goes to DONE.
- DONE: result, carry and zero are held stable. When out_ready is high, go to IDLE. No command is accepted in DONE.
- Result rules (all arithmetic in 2W bits, mod 2^(2W)):
  - ADD: a+b zero-extended. carry = sum bit WIDTH.
  - SUB: a−b in two's complement. carry = borrow (a<b).
  - AND, OR, XOR: bitwise, zero-extended. carry = 0.
  - SHL: {0,a} << b. Bits shifted past 2W are lost. carry = 0.
  - MUL: a*b (exact). carry = 0.
  - MAC: acc ← acc + a*b, and result = the new acc. carry = overflow out of bit 2W−1.
- zero is computed from the registered result.
- Accumulator acc (2W bits) persists across commands. Only MAC and acc_clr modify it.
- acc_clr is honoured only in IDLE and ignored otherwise.
  - If it coincides with acceptance of a MAC, the clear applies first and the MAC sums into 0.
  - If it coincides with any other accepted op, the op proceeds and acc clears.
- Inputs a, b and op are don't-care after acceptance.

## Timing
- Reset (asynchronous, rst_n low): state=IDLE, result=0, carry=0, zero=0, out_valid=0, acc=0, internal counters 0. in_ready goes to 1 once rst_n is high.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. acc returns to 0. No partial result is ever flagged valid.
- Latency, with the command accepted at edge k:
  - Single-cycle ops: out_valid high after edge k+1.
  - MUL/MAC: out_valid high after edge k+WIDTH+1.
- Earliest next acceptance is the edge after the out_valid&&out_ready edge, which gives a peak throughput of 1 op per 2 cycles for single-cycle ops.
- out_valid, once high, stays high with stable data until out_ready is sampled high.

## Test plan
- WIDTH=3, reset release, ADD a=7 b=7 -> after 1 cycle out_valid=1, result=14, carry=1, zero=0; in_ready=0 until out_ready.
- SUB a=2 b=5 -> result=61 (0x3D), carry=1. SUB a=4 b=4 -> result=0, zero=1, carry=0.
- MUL a=7 b=7 -> out_valid exactly 4 cycles after acceptance, result=49. SHL a=5 b=3 -> result=40. SHL a=7 b=7 -> result=0, zero=1.
- MAC a=3 b=5 then MAC a=2 b=2 -> results 15 then 19. Then acc_clr=1 together with MAC a=1 b=1 -> result=1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR a=6 b=3 -> result=5 is held stable, in_ready=0, and further in_valid pulses are ignored. Release -> IDLE next cycle.
- Pull rst_n low in the 2nd BUSY cycle of MAC a=7 b=7 (acc previously 15) -> outputs 0 immediately. After release, MAC a=1 b=1 -> result=1 (acc was cleared).
